rtc_bus_scheduler: RTL
======================

// Module: rtc_bus_scheduler
// PURPOSE
//  Owns the multiplexed address/data bus to the external RTC (CS, RD, WR, AD, A_D_Bus).
//  Arbitrates three requesters by fixed priority and sequences one complete bus transaction
//  at a time: address phase, then data phase, then recovery gap.
//  Requester 0 is IRQ service, 1 is user write (buttons), 2 is the periodic time/date refresh.
//  Sits between the control FSMs and the A_D_Bus tristate, which is built in top.
// PARAMETERS
//  T_SETUP   1  cycles of bus setup before each strobe (>=1)
//  T_STROBE  2  cycles WR/RD held low per strobe (>=1)
//  T_HOLD    1  cycles bus held after each strobe (>=1)
//  T_GAP     2  cycles CS high after a transaction before IDLE (>=1)
// PORTS
//  CLK        in   1   system clock
//  RST        in   1   synchronous reset, active-high
//  req        in   3   per-requester transaction request, level, bit0 highest priority
//  req_we     in   3   per-requester 1=write, 0=read
//  req_addr   in   24  {addr2,addr1,addr0}, 8 bits each, RTC register address
//  req_wdata  in   24  {data2,data1,data0}, 8 bits each, write data
//  gnt        out  3   one-hot, 1-cycle pulse: request captured
//  done       out  1   1-cycle pulse: granted transaction complete
//  rdata      out  8   read data, valid with done, held until the next read completes
//  busy       out  1   1 in every state except IDLE
//  CS         out  1   RTC chip select, active-low
//  RD         out  1   read strobe, active-low
//  WR         out  1   write strobe, active-low (also strobes the address)
//  AD         out  1   0 = address on bus, 1 = data on bus
//  bus_out    out  8   value to drive on A_D_Bus
//  bus_oe     out  1   1 = top drives bus_out onto A_D_Bus
//  bus_in     in   8   A_D_Bus as read back from the pad
// BEHAVIOUR
//  - Reset: CS=RD=WR=AD=1, bus_oe=0, bus_out=0, gnt=0, done=0, rdata=0, busy=0, state=IDLE.
//    RST mid-transaction aborts on the next edge; no done is issued and the grant is lost.
//  - All outputs are registered. States: IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP.
//    Each *_SET, *_STB, *_HLD and GAP state lasts its parameter count, timed by one down-counter.
//  - IDLE: req sampled only here. Winner = lowest set bit.
//    On that edge: latch winner addr/wdata/we; gnt[winner]=1 for one cycle; go to A_SET.
//    req is ignored outside IDLE; a requester still asserting req after done is re-arbitrated.
//  - A_SET/A_STB/A_HLD: CS=0, AD=0, bus_oe=1, bus_out=addr. WR=0 only in A_STB.
//  - D_SET/D_STB/D_HLD: CS=0, AD=1.
//    Write: bus_oe=1, bus_out=wdata, WR=0 only in D_STB.
//    Read: bus_oe=0, RD=0 only in D_STB; rdata<=bus_in on the edge ending the last D_STB cycle.
//  - CS stays low continuously from A_SET through D_HLD. RD and WR are never low together.
//    bus_oe=0 whenever RD=0.
//  - GAP: CS=RD=WR=AD=1, bus_oe=0. done=1 in the first GAP cycle. Then IDLE.
//  - Latency (defaults): req seen at edge n -> gnt and CS=0 from cycle n+1.
//    CS low for 2*(T_SETUP+T_STROBE+T_HOLD)=8 cycles. done at n+9.
//    Next grant earliest at n+12 (one IDLE cycle is mandatory).
//  - Simultaneous requests: strict priority 0>1>2; no aging.
//    Requester 2 may wait while 0 or 1 keep requesting.
// TESTING
//  1 Reset: hold RST 10 cycles with req=3'b111 -> CS=RD=WR=AD=1, bus_oe=0, gnt=0, busy=0 throughout.
//  2 Write req1 addr=8'h21 data=8'h45 -> gnt=3'b010 one cycle; AD=0, bus_out=21, WR low 2 cycles;
//    then AD=1, bus_out=45, WR low 2 cycles; CS low exactly 8 cycles; done once; RD never low.
//  3 Read req2 addr=8'hF1, pad model returns 8'h5A while RD=0 -> bus_oe=0 during D_*; rdata=5A with done.
//  4 req=3'b111 together, each requester holds req until its own gnt -> grants in order 001, 010, 100;
//    consecutive gnt pulses 11 cycles apart.
//  5 Assert RST during D_STB of a write -> next cycle CS=1, WR=1, bus_oe=0, no done, state IDLE.
//  6 Pulse req0 (IRQ service) during a req2 transaction -> ignored until IDLE;
//    req0 granted at the first IDLE, before a still-pending req2.

Source files
------------

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler
//   Owns the multiplexed address/data bus to the external RTC. Three requesters
//   are arbitrated by fixed priority (bit 0 highest). One complete bus
//   transaction runs at a time: address phase, data phase, then a recovery gap
//   with chip select released. The A_D_Bus tristate itself lives in the top level.
//
// Ports
//   CLK, RST   clock, synchronous active-high reset
//   req        per-requester level request (0 = IRQ service, 1 = user write, 2 = refresh)
//   req_we     per-requester direction, 1 = write, 0 = read
//   req_addr   {addr2, addr1, addr0} RTC register addresses
//   req_wdata  {data2, data1, data0} write data
//   gnt        one-hot pulse, request captured
//   done       pulse, granted transaction complete
//   rdata      last read data, updated when a read completes
//   busy       high in every state except IDLE
//   CS/RD/WR   active-low RTC chip select, read strobe, write/address strobe
//   AD         0 = address phase, 1 = data phase
//   bus_out    value to drive on A_D_Bus
//   bus_oe     1 = top drives bus_out onto A_D_Bus
//   bus_in     A_D_Bus as read back from the pad
module rtc_bus_scheduler #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 2,
  parameter int T_HOLD   = 1,
  parameter int T_GAP    = 2,
  parameter int DATA_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2:0]            req,
  input  logic [2:0]            req_we,
  input  logic [3*DATA_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            gnt,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  CS,
  output logic                  RD,
  output logic                  WR,
  output logic                  AD,
  output logic [DATA_W-1:0]     bus_out,
  output logic                  bus_oe,
  input  logic [DATA_W-1:0]     bus_in
);

  localparam int MAX_AB  = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int MAX_CD  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_STB = 3'd2,
    A_HLD = 3'd3,
    D_SET = 3'd4,
    D_STB = 3'd5,
    D_HLD = 3'd6,
    GAP   = 3'd7
  } state_t;

  // Counter preload: a state lasting n cycles counts n-1 down to 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

  // Lowest set bit wins.
  function automatic logic [1:0] win_index(input logic [2:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic is_addr_phase(input state_t s);
    return (s == A_SET) || (s == A_STB) || (s == A_HLD);
  endfunction

  function automatic logic is_data_phase(input state_t s);
    return (s == D_SET) || (s == D_STB) || (s == D_HLD);
  endfunction

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                we_q, we_nxt;
  logic [DATA_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic                capture;
  logic [1:0]          idx;

  logic [2:0]          gnt_nxt;
  logic                done_nxt;
  logic                busy_nxt;
  logic                cs_nxt, rd_nxt, wr_nxt, ad_nxt, oe_nxt;
  logic [DATA_W-1:0]   bus_out_nxt;
  logic                rd_sample;

  state_t              after;
  int                  after_len;

  // Next-state, counter and registered-output decode. Outputs are computed
  // from the state being entered so that every port comes straight off a flop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    gnt_nxt   = 3'b000;
    done_nxt  = 1'b0;
    after     = IDLE;
    after_len = 1;
    idx       = win_index(req);

    case (state)
      A_SET:   begin after = A_STB; after_len = T_STROBE; end
      A_STB:   begin after = A_HLD; after_len = T_HOLD;   end
      A_HLD:   begin after = D_SET; after_len = T_SETUP;  end
      D_SET:   begin after = D_STB; after_len = T_STROBE; end
      D_STB:   begin after = D_HLD; after_len = T_HOLD;   end
      D_HLD:   begin after = GAP;   after_len = T_GAP;    end
      default: begin after = IDLE;  after_len = 1;        end
    endcase

    if (state == IDLE) begin
      if (req != 3'b000) begin
        state_nxt = A_SET;
        cnt_nxt   = cnt_load(T_SETUP);
        capture   = 1'b1;
        gnt_nxt   = req & (~req + 3'b001);
      end
    end else if (cnt == '0) begin
      state_nxt = after;
      cnt_nxt   = cnt_load(after_len);
      done_nxt  = (state == D_HLD);
    end else begin
      cnt_nxt = cnt - 1'b1;
    end

    we_nxt    = capture ? req_we[idx] : we_q;
    addr_nxt  = capture ? req_addr[idx*DATA_W +: DATA_W] : addr_q;
    wdata_nxt = capture ? req_wdata[idx*DATA_W +: DATA_W] : wdata_q;

    busy_nxt    = (state_nxt != IDLE);
    cs_nxt      = ~(is_addr_phase(state_nxt) || is_data_phase(state_nxt));
    ad_nxt      = ~is_addr_phase(state_nxt);
    wr_nxt      = ~((state_nxt == A_STB) || ((state_nxt == D_STB) && we_nxt));
    rd_nxt      = ~((state_nxt == D_STB) && !we_nxt);
    oe_nxt      = is_addr_phase(state_nxt) || (is_data_phase(state_nxt) && we_nxt);
    bus_out_nxt = '0;
    if (is_addr_phase(state_nxt))
      bus_out_nxt = addr_nxt;
    else if (is_data_phase(state_nxt) && we_nxt)
      bus_out_nxt = wdata_nxt;

    // Pad is sampled on the edge that ends the final read-strobe cycle.
    rd_sample = (state == D_STB) && (cnt == '0) && !we_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt     <= 3'b000;
      done    <= 1'b0;
      busy    <= 1'b0;
      CS      <= 1'b1;
      RD      <= 1'b1;
      WR      <= 1'b1;
      AD      <= 1'b1;
      bus_oe  <= 1'b0;
      bus_out <= '0;
      rdata   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
      CS      <= cs_nxt;
      RD      <= rd_nxt;
      WR      <= wr_nxt;
      AD      <= ad_nxt;
      bus_oe  <= oe_nxt;
      bus_out <= bus_out_nxt;
      if (rd_sample)
        rdata <= bus_in;
    end
  end

  // Transaction payload; only meaningful while busy, so no reset needed.
  always_ff @(posedge CLK) begin
    we_q    <= we_nxt;
    addr_q  <= addr_nxt;
    wdata_q <= wdata_nxt;
  end

endmodule
